pdp1_tape_reader: RTL and testbench

//  Paper tape reader controller. Feeds the IO register of the pdp1 core.

---
 rtl/pdp1_tape_reader.sv | 141 ++++++++++++++
 tb/tb_pdp1_tape_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdp1_tape_reader.sv
// Paper tape reader controller for the pdp1 core: pulls frames over valid/ready,
// assembles alpha (one frame) or binary (three channel-8 frames) words into rb.
module pdp1_tape_reader #(
   parameter int unsigned FRAME_DLY = 2500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_rpa,
   input  logic        i_rpb,
   input  logic        i_clr_flag,
   input  logic        i_stop,
   input  logic        i_frame_valid,
   input  logic [7:0]  i_frame_data,
   output logic        o_frame_ready,
   output logic [17:0] o_rb,
   output logic        o_done,
   output logic        o_rb_flag,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] GAP_LOAD = 16'(FRAME_DLY - 1);

   state_t      r_state;
   logic        r_mode_b;
   logic [17:0] r_rb;
   logic [1:0]  r_cnt;
   logic [15:0] r_gap;
   logic        r_last;
   logic        r_flag;

   state_t      w_state_next;
   logic        w_mode_next;
   logic [17:0] w_rb_next;
   logic [1:0]  w_cnt_next;
   logic [15:0] w_gap_next;
   logic        w_last_next;
   logic        w_flag_next;
   logic        w_frame_ready;
   logic        w_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_mode_b <= 1'b0;
         r_rb     <= '0;
         r_cnt    <= '0;
         r_gap    <= '0;
         r_last   <= 1'b0;
         r_flag   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_mode_b <= w_mode_next;
         r_rb     <= w_rb_next;
         r_cnt    <= w_cnt_next;
         r_gap    <= w_gap_next;
         r_last   <= w_last_next;
         r_flag   <= w_flag_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_mode_next   = r_mode_b;
      w_rb_next     = r_rb;
      w_cnt_next    = r_cnt;
      w_gap_next    = r_gap;
      w_last_next   = r_last;
      w_flag_next   = r_flag;
      w_frame_ready = 1'b0;
      w_done        = 1'b0;

      // Clear first so that a DONE set in the same cycle overrides it.
      if (i_clr_flag)
         w_flag_next = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_rpa || i_rpb) begin
               w_mode_next  = i_rpb;
               w_rb_next    = '0;
               w_cnt_next   = '0;
               w_flag_next  = 1'b0;
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            w_frame_ready = !i_stop;
            if (i_stop) begin
               w_state_next = S_IDLE;
            end else if (i_frame_valid) begin
               w_gap_next   = GAP_LOAD;
               w_state_next = S_GAP;
               if (!r_mode_b) begin
                  w_rb_next   = {10'b0, i_frame_data};
                  w_last_next = 1'b1;
               end else if (i_frame_data[7]) begin
                  w_rb_next   = {r_rb[11:0], i_frame_data[5:0]};
                  w_cnt_next  = r_cnt + 2'd1;
                  w_last_next = (r_cnt == 2'd2);
               end else begin
                  // Leader/blank frame: consumed but contributes nothing.
                  w_last_next = 1'b0;
               end
            end
         end
         S_GAP: begin
            if (i_stop)
               w_state_next = S_IDLE;
            else if (r_gap == 16'd0)
               w_state_next = r_last ? S_DONE : S_FETCH;
            else
               w_gap_next = r_gap - 16'd1;
         end
         S_DONE: begin
            if (i_stop) begin
               w_state_next = S_IDLE;
            end else begin
               w_done       = 1'b1;
               w_flag_next  = 1'b1;
               w_cnt_next   = '0;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign o_frame_ready = w_frame_ready;
   assign o_done        = w_done;
   assign o_rb          = r_rb;
   assign o_rb_flag     = r_flag;
   assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_pdp1_tape_reader.sv
// Directed bench for pdp1_tape_reader with a short reader gap (FRAME_DLY=4).
module tb_pdp1_tape_reader;

   localparam int DLY = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_rpa = 1'b0;
   logic        i_rpb = 1'b0;
   logic        i_clr_flag = 1'b0;
   logic        i_stop = 1'b0;
   logic        i_frame_valid = 1'b0;
   logic [7:0]  i_frame_data = 8'h00;
   logic        o_frame_ready;
   logic [17:0] o_rb;
   logic        o_done;
   logic        o_rb_flag;
   logic        o_busy;

   int vectors = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;

   pdp1_tape_reader #(.FRAME_DLY(DLY)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_rpa(i_rpa),
      .i_rpb(i_rpb),
      .i_clr_flag(i_clr_flag),
      .i_stop(i_stop),
      .i_frame_valid(i_frame_valid),
      .i_frame_data(i_frame_data),
      .o_frame_ready(o_frame_ready),
      .o_rb(o_rb),
      .o_done(o_done),
      .o_rb_flag(o_rb_flag),
      .o_busy(o_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (o_done) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
      end
   endtask

   task automatic pulse_rpa();
      i_rpa = 1'b1;
      @(negedge clk);
      i_rpa = 1'b0;
   endtask

   task automatic pulse_rpb();
      i_rpb = 1'b1;
      @(negedge clk);
      i_rpb = 1'b0;
   endtask

   // Presents a frame until the handshake; returns cycles spent waiting and the handshake cycle.
   task automatic send_frame(input logic [7:0] data, output int waited, output int hs_cyc);
      i_frame_valid = 1'b1;
      i_frame_data  = data;
      waited = 0;
      while (!o_frame_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) chk("frame_timeout", 32'(waited), 32'd0);
      hs_cyc = cyc;
      @(negedge clk);
      i_frame_valid = 1'b0;
   endtask

   task automatic wait_done(output int dcyc);
      int n;
      n = 0;
      while (!o_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("done_timeout", 32'(n), 32'd0);
      dcyc = cyc;
   endtask

   task automatic wait_fetch();
      int n;
      n = 0;
      while (!o_frame_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("fetch_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      int w, hs, dc, dc0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(o_frame_ready), 32'd0);
      chk("rst_busy",  32'(o_busy), 32'd0);
      chk("rst_rb",    32'(o_rb), 32'd0);
      chk("rst_flag",  32'(o_rb_flag), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(o_frame_ready), 32'd0);

      // T1: asynchronous reset in the middle of a gap
      pulse_rpa();
      send_frame(8'h3F, w, hs);
      chk("t1_rb_pre", 32'(o_rb), 32'o77);
      chk("t1_busy_pre", 32'(o_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t1_rb_rst",   32'(o_rb), 32'd0);
      chk("t1_busy_rst", 32'(o_busy), 32'd0);
      chk("t1_done_rst", 32'(o_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_ready_after", 32'(o_frame_ready), 32'd0);
      chk("t1_busy_after",  32'(o_busy), 32'd0);

      // T2: binary word with a leading blank frame
      dc0 = done_cnt;
      pulse_rpb();
      chk("t2_busy", 32'(o_busy), 32'd1);
      send_frame(8'h00, w, hs);
      chk("t2_wait0", 32'(w), 32'd0);
      send_frame(8'h81, w, hs);
      chk("t2_gap1", 32'(w), 32'(DLY));
      send_frame(8'h92, w, hs);
      chk("t2_gap2", 32'(w), 32'(DLY));
      send_frame(8'hBF, w, hs);
      chk("t2_gap3", 32'(w), 32'(DLY));
      wait_done(dc);
      chk("t2_latency", 32'(dc - hs), 32'(DLY + 1));
      chk("t2_rb", 32'(o_rb), 32'o012277);
      @(negedge clk);
      chk("t2_flag", 32'(o_rb_flag), 32'd1);
      chk("t2_busy_end", 32'(o_busy), 32'd0);
      chk("t2_done_once", 32'(done_cnt - dc0), 32'd1);
      chk("t2_rb_hold", 32'(o_rb), 32'o012277);

      // T3: alpha frame; command also clears the flag
      pulse_rpa();
      chk("t3_flag_clr", 32'(o_rb_flag), 32'd0);
      send_frame(8'h5A, w, hs);
      wait_done(dc);
      chk("t3_latency", 32'(dc - hs), 32'(DLY + 1));
      chk("t3_rb", 32'(o_rb), 32'o000132);
      @(negedge clk);
      chk("t3_flag", 32'(o_rb_flag), 32'd1);

      // T4: stop coinciding with the third binary frame
      dc0 = done_cnt;
      pulse_rpb();
      send_frame(8'h81, w, hs);
      send_frame(8'hC5, w, hs);
      wait_fetch();
      i_frame_valid = 1'b1;
      i_frame_data  = 8'hBF;
      i_stop        = 1'b1;
      #1;
      chk("t4_ready_stop", 32'(o_frame_ready), 32'd0);
      @(negedge clk);
      i_stop = 1'b0;
      i_frame_valid = 1'b0;
      chk("t4_busy", 32'(o_busy), 32'd0);
      chk("t4_rb_partial", 32'(o_rb), 32'o000105);
      chk("t4_flag", 32'(o_rb_flag), 32'd0);
      repeat (DLY + 3) @(negedge clk);
      chk("t4_no_done", 32'(done_cnt - dc0), 32'd0);

      // T5: clear coinciding with DONE loses to the set
      pulse_rpa();
      send_frame(8'h01, w, hs);
      wait_done(dc);
      i_clr_flag = 1'b1;
      @(negedge clk);
      i_clr_flag = 1'b0;
      chk("t5_set_wins", 32'(o_rb_flag), 32'd1);
      i_clr_flag = 1'b1;
      @(negedge clk);
      i_clr_flag = 1'b0;
      chk("t5_clr", 32'(o_rb_flag), 32'd0);

      // T6: rpa ignored while busy in binary mode
      dc0 = done_cnt;
      pulse_rpb();
      pulse_rpa();
      send_frame(8'h3F, w, hs);
      wait_fetch();
      chk("t6_still_fetch", 32'(o_busy), 32'd1);
      chk("t6_rb_unchanged", 32'(o_rb), 32'd0);
      chk("t6_no_done", 32'(done_cnt - dc0), 32'd0);
      i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;
      chk("t6_stopped", 32'(o_busy), 32'd0);

      // T6: simultaneous rpa/rpb picks binary mode
      i_rpa = 1'b1;
      i_rpb = 1'b1;
      @(negedge clk);
      i_rpa = 1'b0;
      i_rpb = 1'b0;
      send_frame(8'h41, w, hs);
      repeat (DLY + 2) @(negedge clk);
      chk("t6_both_busy", 32'(o_busy), 32'd1);
      chk("t6_both_rb", 32'(o_rb), 32'd0);
      chk("t6_both_ready", 32'(o_frame_ready), 32'd1);
      chk("t6_both_no_done", 32'(done_cnt - dc0), 32'd0);
      i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
